bcd_addsub_serial: RTL and testbench
====================================

BCD_ADDSUB_SERIAL -- requirements
Module: bcd_addsub_serial

Interface
REQ-001 Parameter DIGITS, default 3, number of BCD digits per operand (legal 1..16).
REQ-002 Parameter W, default 4*DIGITS, operand width in bits; SHALL always equal 4*DIGITS.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 x  input  W  BCD operand A, digit 0 in bits [3:0].
REQ-008 y  input  W  BCD operand B, same digit ordering.
REQ-009 cin  input  1  decimal carry-in.
REQ-010 sub  input  1  0 = add, 1 = subtract via nines complement of y.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  W  BCD result.
REQ-014 cout  output  1  decimal carry-out; in subtract mode 1 = no borrow.
REQ-015 err  output  1  at least one accepted input digit of x or y was >9.

Function
REQ-016 FSM states IDLE, CALC, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 IDLE: on in_valid&&in_ready, latch x, y, cin, sub; clear digit counter to 0; go to CALC.
REQ-018 Latch: y SHALL be stored as per-digit (9 - digit) when sub=1, and unchanged when sub=0.
REQ-019 Latch: err SHALL be set if any x or y digit exceeds 9; sum/cout are then don't-care, but timing is unchanged.
REQ-020 CALC: one digit per cycle, LSD first; digit k = x_k + y_eff_k + carry; write the BCD digit into sum[4k+3:4k]; register the carry.
REQ-021 The carry into digit 0 SHALL be the latched cin.
REQ-022 CALC with counter = DIGITS-1: go to DONE; cout = carry out of the last digit.
REQ-023 Latency: out_valid SHALL rise exactly DIGITS clock edges after the accepting edge.
REQ-024 DONE: sum, cout and err SHALL be held stable until out_valid&&out_ready; on that edge go to IDLE.
REQ-025 in_valid while busy is ignored; the source must hold its request until in_ready.
REQ-026 DIGITS=1: CALC lasts exactly one cycle.
REQ-027 Minimum initiation interval SHALL be DIGITS+2 cycles (accept, DIGITS-1 further CALC cycles, DONE, IDLE).
REQ-028 Inputs x, y, cin, sub SHALL NOT affect any output after the accepting edge.

Reset
REQ-029 With rst_n low: state = IDLE, counter = 0, sum = 0, cout = 0, err = 0, out_valid = 0, in_ready = 1.
REQ-030 Reset asserted mid-CALC or in DONE SHALL abort the operation with no result delivered; the first accept after rst_n rises SHALL behave normally.

Structure
REQ-031 Shared package bcd_pkg: DIGIT_W = 4, DIGIT_MAX = 9, and the FSM state enum.
REQ-032 Exactly one instance of the existing single-digit bcd_adder SHALL form the datapath; operand registers shift right 4 bits per CALC cycle.
REQ-033 The counter width is $clog2(DIGITS) bits, minimum 1.

Verification
REQ-034 DIGITS=3, add, x=456, y=789, cin=0 -> sum=245, cout=1, err=0; out_valid exactly 3 edges after accept.
REQ-035 Add, x=999, y=001, cin=0 -> sum=000, cout=1; carry ripples through all digits.
REQ-036 Subtract, x=500, y=123, cin=1 -> sum=377, cout=1; x=123, y=500, cin=1 -> sum=623, cout=0 (borrow).
REQ-037 x=0x1A0, y=000 -> err=1; next op with valid digits -> err=0.
REQ-038 out_ready held low for 5 cycles in DONE -> sum/cout stable, in_ready=0; release -> IDLE next cycle, new accept works.
REQ-039 rst_n pulsed low during CALC digit 1 -> out_valid never rises for that op; all outputs match REQ-029; next op 456+789 is correct.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants, FSM state type and digit helper
//
// Purpose: common definitions for the serial BCD add/subtract slice.
// Contents: DIGIT_W, DIGIT_MAX, state_t (IDLE/CALC/DONE), nines().
package bcd_pkg;

    localparam int DIGIT_W   = 4;
    localparam int DIGIT_MAX = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Nines complement of one digit; meaningless for digits above 9, which
    // are flagged separately through err.
    function automatic logic [DIGIT_W-1:0] nines(input logic [DIGIT_W-1:0] d);
        return DIGIT_W'(DIGIT_MAX) - d;
    endfunction

endpackage

// File: rtl/bcd_adder.sv
// rtl/bcd_adder.sv - single-digit combinational BCD adder
//
// Purpose: adds two BCD digits plus a carry, producing a BCD digit and carry.
// Ports:
//   a, b  in   DIGIT_W  BCD digits
//   ci    in   1        decimal carry-in
//   s     out  DIGIT_W  BCD result digit
//   co    out  1        decimal carry-out
module bcd_adder
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               ci,
    output logic [DIGIT_W-1:0] s,
    output logic               co
);

    logic [DIGIT_W:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, ci};
        co  = raw > (DIGIT_W+1)'(DIGIT_MAX);
        // Binary sums 10..19 are corrected by +6; the wrap into bit DIGIT_W
        // is exactly the decimal carry already reported in co.
        if (co) begin
            s = DIGIT_W'(raw + (DIGIT_W+1)'(6));
        end else begin
            s = raw[DIGIT_W-1:0];
        end
    end

endmodule

// File: rtl/bcd_addsub_serial.sv
// rtl/bcd_addsub_serial.sv - digit-serial BCD adder/subtractor, LSD first
//
// Purpose: latches two DIGITS-digit BCD operands, then adds (or subtracts via
// the nines complement of y) one digit per clock through a single bcd_adder.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operand handshake (in_ready only in IDLE)
//   x, y, cin, sub       operands, decimal carry-in, 1 = subtract
//   out_valid, out_ready result handshake (out_valid only in DONE)
//   sum, cout, err       BCD result, carry-out (1 = no borrow), bad-digit flag
module bcd_addsub_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int W      = 4 * DIGITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         err
);

    localparam int                CNT_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]  LAST_DIGIT = CNT_W'(DIGITS - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     x_sh;
    logic [W-1:0]     y_sh;
    logic [W-1:0]     sum_r;
    logic             carry;
    logic             cout_r;
    logic             err_r;

    logic [W-1:0]       y_eff;
    logic               bad_digit;
    logic               accept;
    logic [DIGIT_W-1:0] d_sum;
    logic               d_co;

    assign accept    = in_valid && (state == IDLE);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign err       = err_r;

    // Operand conditioning at the latch point: complement y for subtract and
    // check the raw digits of both operands.
    always_comb begin
        y_eff     = y;
        bad_digit = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (sub) begin
                y_eff[k*DIGIT_W +: DIGIT_W] = nines(y[k*DIGIT_W +: DIGIT_W]);
            end
            if (x[k*DIGIT_W +: DIGIT_W] > DIGIT_W'(DIGIT_MAX) ||
                y[k*DIGIT_W +: DIGIT_W] > DIGIT_W'(DIGIT_MAX)) begin
                bad_digit = 1'b1;
            end
        end
    end

    bcd_adder u_digit (
        .a  (x_sh[DIGIT_W-1:0]),
        .b  (y_sh[DIGIT_W-1:0]),
        .ci (carry),
        .s  (d_sum),
        .co (d_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (cnt == LAST_DIGIT) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            x_sh   <= '0;
            y_sh   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            err_r  <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            x_sh  <= x;
            y_sh  <= y_eff;
            carry <= cin;
            err_r <= bad_digit;
        end else if (state == CALC) begin
            // The adder always looks at the bottom digit, so both operands
            // shift down one digit per cycle.
            x_sh  <= x_sh >> DIGIT_W;
            y_sh  <= y_sh >> DIGIT_W;
            sum_r[cnt*DIGIT_W +: DIGIT_W] <= d_sum;
            carry <= d_co;
            if (cnt == LAST_DIGIT) begin
                cnt    <= '0;
                cout_r <= d_co;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// tb/tb_bcd_addsub_serial.sv - self-checking bench for bcd_addsub_serial
module tb_bcd_addsub_serial;

    localparam int DIGITS = 3;
    localparam int W      = 4 * DIGITS;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;
    exp_t q[$];
    logic busy = 1'b0;
    logic first = 1'b1;
    logic prev_hs = 1'b0;
    logic [W-1:0] got_sum;
    logic         got_cout;
    logic         got_err;

    bcd_addsub_serial #(.DIGITS(DIGITS), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic int bcd_val(input logic [W-1:0] v);
        int r = 0;
        for (int k = DIGITS - 1; k >= 0; k--) r = r * 10 + int'(v[k*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int n);
        logic [W-1:0] r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[k*4 +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    // Decimal arithmetic: subtract is x + (10^D - 1 - y) + cin.
    function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] ya,
                                   input logic ci, input logic sb);
        exp_t e;
        int lim = 10 ** DIGITS;
        int yy;
        int r;
        e.err = 1'b0;
        for (int k = 0; k < DIGITS; k++)
            if (xa[k*4 +: 4] > 4'd9 || ya[k*4 +: 4] > 4'd9) e.err = 1'b1;
        yy = sb ? (lim - 1 - bcd_val(ya)) : bcd_val(ya);
        r = bcd_val(xa) + yy + int'(ci);
        e.sum  = to_bcd(r % lim);
        e.cout = (r >= lim);
        e.acc  = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            busy    = 1'b0;
            first   = 1'b1;
            prev_hs = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_sum", sum, 0);
            chk("rst_cout", cout, 0);
            chk("rst_err", err, 0);
        end else begin
            if (prev_hs) chk("idle_after_done", {out_valid, in_ready}, 2'b01);
            prev_hs = 1'b0;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    e = q[0];
                    if (first) chk("latency", cyc - e.acc, DIGITS);
                    first = 1'b0;
                    chk("done_in_ready", in_ready, 0);
                    chk("err", err, e.err);
                    if (!e.err) begin
                        chk("sum", sum, e.sum);
                        chk("cout", cout, e.cout);
                    end
                    if (out_ready) begin
                        got_sum  = sum;
                        got_cout = cout;
                        got_err  = err;
                        void'(q.pop_front());
                        first   = 1'b1;
                        prev_hs = 1'b1;
                        busy    = 1'b0;
                        n_done++;
                    end
                end
            end else if (busy) begin
                chk("calc_in_ready", in_ready, 0);
            end
            if (in_valid && in_ready) begin
                e = model(x, y, cin, sub);
                e.acc = cyc + 1;
                q.push_back(e);
                busy = 1'b1;
            end
        end
    end

    task automatic do_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] ya,
                         input logic ci, input logic sb, input int hold, input logic chk_val,
                         input logic [W-1:0] es, input logic ec, input logic ee);
        int n;
        int d0 = n_done;
        @(posedge clk); #1;
        x = xa; y = ya; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = W'($urandom); y = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        n = 0;
        while (n_done == d0 && n < 10) begin @(posedge clk); #1; n++; end
        out_ready = 1'b0;
        if (n_done == d0) begin
            chk({name, "_timeout"}, 0, 1);
        end else begin
            chk({name, "_lit_err"}, got_err, ee);
            if (chk_val) begin
                chk({name, "_lit_sum"}, got_sum, es);
                chk({name, "_lit_cout"}, got_cout, ec);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        do_op("add_456_789", 12'h456, 12'h789, 1'b0, 1'b0, 0, 1'b1, 12'h245, 1'b1, 1'b0);
        do_op("add_ripple",  12'h999, 12'h001, 1'b0, 1'b0, 0, 1'b1, 12'h000, 1'b1, 1'b0);
        do_op("sub_500_123", 12'h500, 12'h123, 1'b1, 1'b1, 0, 1'b1, 12'h377, 1'b1, 1'b0);
        do_op("sub_borrow",  12'h123, 12'h500, 1'b1, 1'b1, 0, 1'b1, 12'h623, 1'b0, 1'b0);
        do_op("bad_digit",   12'h1A0, 12'h000, 1'b0, 1'b0, 0, 1'b0, 12'h000, 1'b0, 1'b1);
        do_op("err_clears",  12'h012, 12'h034, 1'b1, 1'b0, 0, 1'b1, 12'h047, 1'b0, 1'b0);
        do_op("hold_done",   12'h250, 12'h250, 1'b0, 1'b0, 5, 1'b1, 12'h500, 1'b0, 1'b0);
        do_op("sub_cin0",    12'h100, 12'h001, 1'b0, 1'b1, 0, 1'b1, 12'h098, 1'b1, 1'b0);
        do_op("cin_only",    12'h000, 12'h000, 1'b1, 1'b0, 0, 1'b1, 12'h001, 1'b0, 1'b0);
        do_op("cin_ripple",  12'h998, 12'h001, 1'b1, 1'b0, 2, 1'b1, 12'h000, 1'b1, 1'b0);

        // Abort an operation after its first digit has been computed.
        @(posedge clk); #1;
        x = 12'h456; y = 12'h789; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (DIGITS + 4) @(posedge clk);
        #1 out_ready = 1'b0;

        do_op("after_reset", 12'h456, 12'h789, 1'b0, 1'b0, 0, 1'b1, 12'h245, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
